// File: rtl/fifo_rd_arb_pkg.sv
// Shared types, defaults and helpers for the FIFO read-side arbiter.
package fifo_rd_arb_pkg;

   localparam int unsigned NUM_REQ_DEF   = 4;
   localparam int unsigned BURST_MAX_DEF = 8;
   localparam int unsigned LEN_W_DEF     = 4;
   localparam int unsigned STALL_MAX_DEF = 16;
   localparam int unsigned DATA_LAT_DEF  = 2;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      BURST = 2'd1,
      DONE  = 2'd2
   } state_e;

   // Requested length -> pops actually issued: 0 still pops once, long requests are capped.
   function automatic int unsigned clamp_len(input int unsigned len, input int unsigned burst_max);
      if (len == 0) return 1;
      if (len > burst_max) return burst_max;
      return len;
   endfunction

endpackage

// File: rtl/d_ff_async.sv
// Generic register cell with asynchronous active-low reset.
//   clk   : clock
//   rst_n : async reset, active low, clears q_o
//   d_i   : next value
//   q_o   : registered value
module d_ff_async #(
   parameter int unsigned SIZE = 1
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [SIZE-1:0] d_i,
   output logic [SIZE-1:0] q_o
);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) q_o <= '0;
      else        q_o <= d_i;
   end

endmodule

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set request at or after the pointer, wrapping.
//   req_i   : request vector
//   ptr_i   : highest-priority index this round
//   gnt_o   : one-hot winner (zero when nothing requests)
//   idx_o   : winner index
//   valid_o : some request is set
module rr_arbiter #(
   parameter  int unsigned NUM_REQ = 4,
   localparam int unsigned ID_W    = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req_i,
   input  logic [ID_W-1:0]    ptr_i,
   output logic [NUM_REQ-1:0] gnt_o,
   output logic [ID_W-1:0]    idx_o,
   output logic               valid_o
);

   logic [ID_W:0] cand;

   // Scan from the pointer outwards; the first hit locks the result.
   always_comb begin
      gnt_o   = '0;
      idx_o   = '0;
      valid_o = 1'b0;
      cand    = '0;
      for (int i = 0; i < int'(NUM_REQ); i++) begin
         cand = {1'b0, ptr_i} + (ID_W+1)'(i);
         if (cand >= (ID_W+1)'(NUM_REQ)) cand = cand - (ID_W+1)'(NUM_REQ);
         if (!valid_o && req_i[cand[ID_W-1:0]]) begin
            valid_o                = 1'b1;
            idx_o                  = cand[ID_W-1:0];
            gnt_o[cand[ID_W-1:0]] = 1'b1;
         end
      end
   end

endmodule

// File: rtl/fifo_rd_arbiter.sv
// Read-side controller for the async FIFO: round-robin grants a consumer, pops a
// burst of up to BURST_MAX words, tags returned beats with their owner and ends
// bursts that starve for STALL_MAX consecutive cycles.
//   r_clk, rrst_n : read clock, async active-low reset
//   req, req_len  : per-consumer request level and packed burst length
//   r_empty       : FIFO empty flag
//   r_en          : FIFO pop (combinational from r_empty)
//   gnt           : registered one-hot grant
//   rd_valid/rd_owner : read data valid and the consumer it belongs to
//   done, short   : end-of-burst pulse to the owner, short = ended by stall timeout
module fifo_rd_arbiter
   import fifo_rd_arb_pkg::*;
#(
   parameter  int unsigned NUM_REQ   = NUM_REQ_DEF,
   parameter  int unsigned BURST_MAX = BURST_MAX_DEF,
   parameter  int unsigned LEN_W     = LEN_W_DEF,
   parameter  int unsigned STALL_MAX = STALL_MAX_DEF,
   parameter  int unsigned DATA_LAT  = DATA_LAT_DEF,
   localparam int unsigned ID_W      = $clog2(NUM_REQ)
) (
   input  logic                     r_clk,
   input  logic                     rrst_n,
   input  logic [NUM_REQ-1:0]       req,
   input  logic [NUM_REQ*LEN_W-1:0] req_len,
   input  logic                     r_empty,
   output logic                     r_en,
   output logic [NUM_REQ-1:0]       gnt,
   output logic                     rd_valid,
   output logic [ID_W-1:0]          rd_owner,
   output logic [NUM_REQ-1:0]       done,
   output logic                     short
);

   localparam int unsigned CNT_W  = $clog2(BURST_MAX + 1);
   localparam int unsigned STL_W  = $clog2(STALL_MAX + 1);
   localparam int unsigned PIPE_W = ID_W + 1;

   state_e             state_q, state_d;
   logic [ID_W-1:0]    ptr_q, ptr_d;
   logic [ID_W-1:0]    owner_q, owner_d;
   logic [CNT_W-1:0]   remaining_q, remaining_d;
   logic [STL_W-1:0]   stall_q, stall_d;
   logic [NUM_REQ-1:0] gnt_q, gnt_d;
   logic [NUM_REQ-1:0] done_q, done_d;
   logic               short_q, short_d;

   logic [NUM_REQ-1:0] win_gnt;
   logic [ID_W-1:0]    win_idx;
   logic               win_valid;
   logic [LEN_W-1:0]   len_arr [NUM_REQ];
   logic [LEN_W-1:0]   win_len;
   logic               pop;

   rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
      .req_i   (req),
      .ptr_i   (ptr_q),
      .gnt_o   (win_gnt),
      .idx_o   (win_idx),
      .valid_o (win_valid)
   );

   // Unpack per-consumer lengths so the winner's field is a plain array lookup.
   for (genvar i = 0; i < int'(NUM_REQ); i++) begin : g_len
      assign len_arr[i] = req_len[i*LEN_W +: LEN_W];
   end
   assign win_len = len_arr[win_idx];

   // Pops only inside a burst with words left; remaining is never 0 in BURST but guard anyway.
   assign pop  = (state_q == BURST) && !r_empty && (remaining_q != '0);
   assign r_en = pop;

   // State and counter registers.
   always_ff @(posedge r_clk or negedge rrst_n) begin
      if (!rrst_n) begin
         state_q     <= IDLE;
         ptr_q       <= '0;
         owner_q     <= '0;
         remaining_q <= '0;
         stall_q     <= '0;
         gnt_q       <= '0;
         done_q      <= '0;
         short_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         ptr_q       <= ptr_d;
         owner_q     <= owner_d;
         remaining_q <= remaining_d;
         stall_q     <= stall_d;
         gnt_q       <= gnt_d;
         done_q      <= done_d;
         short_q     <= short_d;
      end
   end

   // Next-state and registered-output decode.
   always_comb begin
      state_d     = state_q;
      ptr_d       = ptr_q;
      owner_d     = owner_q;
      remaining_d = remaining_q;
      stall_d     = stall_q;
      gnt_d       = gnt_q;
      done_d      = '0;
      short_d     = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (win_valid) begin
               state_d     = BURST;
               gnt_d       = win_gnt;
               owner_d     = win_idx;
               remaining_d = CNT_W'(clamp_len(32'(win_len), BURST_MAX));
               stall_d     = '0;
            end
         end

         BURST: begin
            if (pop) begin
               remaining_d = remaining_q - CNT_W'(1);
               stall_d     = '0;
            end else if (r_empty && (stall_q != STL_W'(STALL_MAX))) begin
               stall_d = stall_q + STL_W'(1);
            end

            // gnt_q is one-hot on the owner, so it doubles as the done vector.
            if (pop && (remaining_q == CNT_W'(1))) begin
               state_d = DONE;
               gnt_d   = '0;
               done_d  = gnt_q;
            end else if (stall_d == STL_W'(STALL_MAX)) begin
               state_d = DONE;
               gnt_d   = '0;
               done_d  = gnt_q;
               short_d = 1'b1;
            end
         end

         DONE: begin
            state_d = IDLE;
            ptr_d   = (owner_q == ID_W'(NUM_REQ - 1)) ? '0 : owner_q + ID_W'(1);
         end

         default: state_d = IDLE;
      endcase
   end

   assign gnt   = gnt_q;
   assign done  = done_q;
   assign short = short_q;

   // Beat tagging: (valid, owner) travels DATA_LAT stages alongside the FIFO read latency.
   logic [PIPE_W-1:0] pipe [DATA_LAT+1];
   assign pipe[0] = {pop, owner_q};

   for (genvar s = 0; s < int'(DATA_LAT); s++) begin : g_pipe
      d_ff_async #(.SIZE(PIPE_W)) u_stage (
         .clk   (r_clk),
         .rst_n (rrst_n),
         .d_i   (pipe[s]),
         .q_o   (pipe[s+1])
      );
   end

   assign rd_valid = pipe[DATA_LAT][ID_W];
   assign rd_owner = pipe[DATA_LAT][ID_W-1:0];

endmodule

// File: tb/tb_fifo_rd_arbiter.sv
// Self-checking bench for fifo_rd_arbiter: directed scenarios plus randomized
// bursts compared against a transaction-level model of arbitration and popping.
module tb_fifo_rd_arbiter;

   localparam int NR = 4;
   localparam int BM = 8;
   localparam int LW = 4;
   localparam int SM = 16;
   localparam int DL = 2;
   localparam int IW = $clog2(NR);

   logic              clk = 1'b0;
   logic              rst_n = 1'b1;
   logic [NR-1:0]     req = '0;
   logic [NR*LW-1:0]  req_len = '0;
   logic              r_empty = 1'b1;
   logic              r_en;
   logic [NR-1:0]     gnt;
   logic              rd_valid;
   logic [IW-1:0]     rd_owner;
   logic [NR-1:0]     done;
   logic              short;

   fifo_rd_arbiter #(
      .NUM_REQ(NR), .BURST_MAX(BM), .LEN_W(LW), .STALL_MAX(SM), .DATA_LAT(DL)
   ) dut (
      .r_clk(clk), .rrst_n(rst_n), .req(req), .req_len(req_len), .r_empty(r_empty),
      .r_en(r_en), .gnt(gnt), .rd_valid(rd_valid), .rd_owner(rd_owner),
      .done(done), .short(short)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   int cyc = 0;
   int words = 0;
   bit force_empty = 1'b0;
   bit rand_gaps = 1'b0;
   int ptr_m = 0;
   int req_cyc = 0;

   int pops, first_pop_cyc, last_pop_cyc, first_gnt_cyc, gnt_idx, done_cyc, first_beat_cyc;
   logic [NR-1:0] done_seen;
   logic          short_seen;
   bit            timed_out;
   int            beats_q[$];
   int multi_gnt = 0, en_while_empty = 0, en_outside = 0, short_stray = 0;

   function automatic int clamp_m(input int l);
      if (l == 0) return 1;
      if (l > BM) return BM;
      return l;
   endfunction

   function automatic int win_m(input logic [NR-1:0] r, input int p);
      for (int k = 0; k < NR; k++) begin
         int j;
         j = (p + k) % NR;
         if (r[j]) return j;
      end
      return -1;
   endfunction

   function automatic logic [NR-1:0] onehot(input int i);
      logic [NR-1:0] v;
      v = '0;
      v[i] = 1'b1;
      return v;
   endfunction

   task automatic set_len(input int i, input int l);
      req_len[i*LW +: LW] = LW'(l);
   endtask

   task automatic drive_empty();
      r_empty = (words == 0) || force_empty;
   endtask

   task automatic clear_obs();
      pops = 0; first_pop_cyc = -1; last_pop_cyc = -1; first_gnt_cyc = -1;
      gnt_idx = -1; done_cyc = -1; done_seen = '0; short_seen = 1'b0;
   endtask

   task automatic clear_beats();
      beats_q.delete();
      first_beat_cyc = -1;
   endtask

   // One clock: sample at negedge, update FIFO occupancy after the posedge.
   task automatic tick();
      logic s_pop;
      @(negedge clk);
      cyc++;
      s_pop = r_en;
      if ($countones(gnt) > 1) multi_gnt++;
      if (r_en && r_empty) en_while_empty++;
      if (r_en && gnt == '0) en_outside++;
      if (short && done == '0) short_stray++;
      if (gnt != '0 && first_gnt_cyc < 0) begin
         first_gnt_cyc = cyc;
         for (int k = 0; k < NR; k++) if (gnt[k]) gnt_idx = k;
      end
      if (r_en) begin
         pops++;
         if (first_pop_cyc < 0) first_pop_cyc = cyc;
         last_pop_cyc = cyc;
      end
      if (done != '0) begin
         done_seen  = done;
         short_seen = short;
         done_cyc   = cyc;
      end
      if (rd_valid) begin
         beats_q.push_back(int'(rd_owner));
         if (first_beat_cyc < 0) first_beat_cyc = cyc;
      end
      @(posedge clk);
      #1;
      if (s_pop && words > 0) words--;
      if (rand_gaps) force_empty = ($urandom_range(0, 3) == 0);
      drive_empty();
   endtask

   task automatic run_until_done(input int budget);
      timed_out = 1'b1;
      for (int k = 0; k < budget; k++) begin
         tick();
         if (done_seen != '0) begin
            timed_out = 1'b0;
            break;
         end
      end
   endtask

   task automatic drain(input int n);
      req = '0;
      repeat (n) tick();
   endtask

   task automatic test_reset();
      #2 rst_n = 1'b0;
      tick();
      tick();
      n_tests++; if (gnt !== '0)     begin n_fail++; $display("FAIL reset_gnt: got %b expected 0", gnt); end
      n_tests++; if (done !== '0)    begin n_fail++; $display("FAIL reset_done: got %b expected 0", done); end
      n_tests++; if (short !== 1'b0) begin n_fail++; $display("FAIL reset_short: got %b expected 0", short); end
      n_tests++; if (r_en !== 1'b0)  begin n_fail++; $display("FAIL reset_r_en: got %b expected 0", r_en); end
      n_tests++; if (rd_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rd_valid: got %b expected 0", rd_valid); end
      n_tests++; if (rd_owner !== '0) begin n_fail++; $display("FAIL reset_rd_owner: got %0d expected 0", rd_owner); end
      rst_n = 1'b1;
      ptr_m = 0;
      tick();
   endtask

   task automatic test_round_robin();
      int prev_done;
      int exp_idx;
      words = 100; drive_empty();
      for (int i = 0; i < NR; i++) set_len(i, 2);
      clear_beats();
      req = '1;
      req_cyc = cyc + 1;
      prev_done = -1;
      for (int b = 0; b < 5; b++) begin
         clear_obs();
         run_until_done(20);
         exp_idx = win_m('1, ptr_m);
         n_tests++; if (timed_out) begin n_fail++; $display("FAIL rr_timeout: burst %0d got no done within 20 cycles, expected done", b); end
         n_tests++; if (gnt_idx != exp_idx) begin n_fail++; $display("FAIL rr_order: burst %0d got %0d expected %0d", b, gnt_idx, exp_idx); end
         n_tests++; if (done_seen !== onehot(exp_idx)) begin n_fail++; $display("FAIL rr_done: burst %0d got %b expected %b", b, done_seen, onehot(exp_idx)); end
         n_tests++; if (pops != 2) begin n_fail++; $display("FAIL rr_pops: burst %0d got %0d expected 2", b, pops); end
         if (b == 0) begin
            n_tests++; if (first_gnt_cyc != req_cyc + 1) begin n_fail++; $display("FAIL rr_first_gnt: got %0d expected %0d", first_gnt_cyc, req_cyc + 1); end
         end else begin
            n_tests++; if (first_gnt_cyc != prev_done + 2) begin n_fail++; $display("FAIL rr_regrant: got %0d expected %0d", first_gnt_cyc, prev_done + 2); end
         end
         prev_done = done_cyc;
         ptr_m = (exp_idx + 1) % NR;
      end
      drain(DL + 2);
      n_tests++; if (beats_q.size() != 10) begin n_fail++; $display("FAIL rr_beats: got %0d expected 10", beats_q.size()); end
      n_tests++; if (multi_gnt != 0) begin n_fail++; $display("FAIL rr_onehot: got %0d multi-grant cycles expected 0", multi_gnt); end
   endtask

   task automatic test_single();
      int bad_owner;
      words = 10; drive_empty();
      set_len(0, 4);
      clear_obs(); clear_beats();
      req = 4'b0001;
      req_cyc = cyc + 1;
      run_until_done(40);
      n_tests++; if (timed_out) begin n_fail++; $display("FAIL single_timeout: got no done expected done"); end
      n_tests++; if (gnt_idx != 0) begin n_fail++; $display("FAIL single_gnt: got %0d expected 0", gnt_idx); end
      n_tests++; if (first_gnt_cyc != req_cyc + 1) begin n_fail++; $display("FAIL single_gnt_cyc: got %0d expected %0d", first_gnt_cyc, req_cyc + 1); end
      n_tests++; if (pops != 4) begin n_fail++; $display("FAIL single_pops: got %0d expected 4", pops); end
      n_tests++; if (first_pop_cyc != req_cyc + 1 || last_pop_cyc != req_cyc + 4) begin n_fail++; $display("FAIL single_pop_window: got %0d..%0d expected %0d..%0d", first_pop_cyc, last_pop_cyc, req_cyc + 1, req_cyc + 4); end
      n_tests++; if (done_seen !== 4'b0001 || done_cyc != req_cyc + 5) begin n_fail++; $display("FAIL single_done: got %b at %0d expected 0001 at %0d", done_seen, done_cyc, req_cyc + 5); end
      n_tests++; if (short_seen !== 1'b0) begin n_fail++; $display("FAIL single_short: got %b expected 0", short_seen); end
      drain(DL + 2);
      bad_owner = 0;
      foreach (beats_q[k]) if (beats_q[k] != 0) bad_owner++;
      n_tests++; if (beats_q.size() != 4 || bad_owner != 0) begin n_fail++; $display("FAIL single_beats: got %0d beats (%0d wrong owner) expected 4 owner 0", beats_q.size(), bad_owner); end
      n_tests++; if (first_beat_cyc != req_cyc + 1 + DL) begin n_fail++; $display("FAIL single_beat_lat: got %0d expected %0d", first_beat_cyc, req_cyc + 1 + DL); end
      ptr_m = 1;
   endtask

   task automatic test_stall_gap();
      int pops_before;
      words = 10; drive_empty();
      set_len(2, 5);
      clear_obs(); clear_beats();
      req = 4'b0100;
      for (int k = 0; k < 10; k++) begin
         tick();
         if (pops == 2) break;
      end
      pops_before = pops;
      force_empty = 1'b1; drive_empty();
      repeat (3) tick();
      force_empty = 1'b0; drive_empty();
      n_tests++; if (pops != 2 || pops_before != 2) begin n_fail++; $display("FAIL gap_hold: got %0d pops after gap expected 2", pops); end
      run_until_done(30);
      n_tests++; if (timed_out || pops != 5) begin n_fail++; $display("FAIL gap_pops: got %0d (timeout %0d) expected 5", pops, timed_out); end
      n_tests++; if (done_seen !== 4'b0100 || short_seen !== 1'b0) begin n_fail++; $display("FAIL gap_done: got %b short %b expected 0100 short 0", done_seen, short_seen); end
      n_tests++; if (done_cyc != first_gnt_cyc + 8) begin n_fail++; $display("FAIL gap_done_cyc: got %0d expected %0d", done_cyc, first_gnt_cyc + 8); end
      drain(DL + 2);
      n_tests++; if (beats_q.size() != 5) begin n_fail++; $display("FAIL gap_beats: got %0d expected 5", beats_q.size()); end
      ptr_m = 3;
   endtask

   task automatic test_stall_timeout();
      words = 3; drive_empty();
      set_len(3, 8);
      clear_obs(); clear_beats();
      req = 4'b1000;
      run_until_done(60);
      n_tests++; if (timed_out) begin n_fail++; $display("FAIL to_timeout: got no done expected done"); end
      n_tests++; if (pops != 3) begin n_fail++; $display("FAIL to_pops: got %0d expected 3", pops); end
      n_tests++; if (done_seen !== 4'b1000 || short_seen !== 1'b1) begin n_fail++; $display("FAIL to_done: got %b short %b expected 1000 short 1", done_seen, short_seen); end
      n_tests++; if (done_cyc != last_pop_cyc + SM + 1) begin n_fail++; $display("FAIL to_done_cyc: got %0d expected %0d", done_cyc, last_pop_cyc + SM + 1); end
      drain(DL + 2);
      n_tests++; if (beats_q.size() != 3) begin n_fail++; $display("FAIL to_beats: got %0d expected 3", beats_q.size()); end
      ptr_m = 0;
   endtask

   task automatic test_clamp();
      int lens [2];
      int expp [2];
      lens[0] = 0;  expp[0] = 1;
      lens[1] = 15; expp[1] = BM;
      for (int t = 0; t < 2; t++) begin
         words = 20; drive_empty();
         set_len(1, lens[t]);
         clear_obs(); clear_beats();
         req = 4'b0010;
         run_until_done(30);
         n_tests++; if (timed_out || pops != expp[t]) begin n_fail++; $display("FAIL clamp_pops: len %0d got %0d expected %0d", lens[t], pops, expp[t]); end
         n_tests++; if (short_seen !== 1'b0 || done_cyc != first_gnt_cyc + expp[t]) begin n_fail++; $display("FAIL clamp_done: len %0d got short %b cyc %0d expected short 0 cyc %0d", lens[t], short_seen, done_cyc, first_gnt_cyc + expp[t]); end
         drain(DL + 2);
         n_tests++; if (beats_q.size() != expp[t]) begin n_fail++; $display("FAIL clamp_beats: len %0d got %0d expected %0d", lens[t], beats_q.size(), expp[t]); end
      end
      ptr_m = 2;
   endtask

   task automatic test_reset_mid();
      words = 10; drive_empty();
      set_len(2, 6);
      set_len(1, 3);
      clear_obs();
      req = 4'b0100;
      for (int k = 0; k < 10; k++) begin
         tick();
         if (pops == 2) break;
      end
      n_tests++; if (gnt_idx != 2) begin n_fail++; $display("FAIL rstmid_pre_gnt: got %0d expected 2", gnt_idx); end
      clear_beats();
      rst_n = 1'b0;
      #1;
      n_tests++; if (r_en !== 1'b0 || gnt !== '0 || done !== '0 || short !== 1'b0 || rd_valid !== 1'b0)
         begin n_fail++; $display("FAIL rstmid_outputs: got r_en %b gnt %b done %b short %b rd_valid %b expected all 0", r_en, gnt, done, short, rd_valid); end
      req = 4'b0110;
      clear_obs();
      tick();
      tick();
      rst_n = 1'b1;
      ptr_m = 0;
      n_tests++; if (done_seen !== '0 || beats_q.size() != 0) begin n_fail++; $display("FAIL rstmid_no_done: got done %b beats %0d expected 0 and 0", done_seen, beats_q.size()); end
      clear_obs();
      run_until_done(30);
      n_tests++; if (timed_out || gnt_idx != win_m(4'b0110, 0)) begin n_fail++; $display("FAIL rstmid_regrant: got %0d expected %0d", gnt_idx, win_m(4'b0110, 0)); end
      drain(DL + 2);
      n_tests++; if (beats_q.size() != 3) begin n_fail++; $display("FAIL rstmid_beats: got %0d expected 3", beats_q.size()); end
      ptr_m = 2;
   endtask

   task automatic test_random();
      logic [NR-1:0] mask;
      int lens [NR];
      int exp_idx, exp_l, exp_pops, bad_owner, exp_done;
      bit exp_short;
      for (int it = 0; it < 40; it++) begin
         mask = NR'($urandom_range(1, (1 << NR) - 1));
         for (int i = 0; i < NR; i++) begin
            lens[i] = $urandom_range(0, (1 << LW) - 1);
            set_len(i, lens[i]);
         end
         words = $urandom_range(0, 12);
         rand_gaps = ($urandom_range(0, 1) == 1);
         drive_empty();
         exp_idx   = win_m(mask, ptr_m);
         exp_l     = clamp_m(lens[exp_idx]);
         exp_pops  = (words < exp_l) ? words : exp_l;
         exp_short = (words < exp_l);
         clear_obs(); clear_beats();
         req = mask;
         run_until_done(80);
         rand_gaps = 1'b0;
         force_empty = 1'b0;
         drive_empty();
         n_tests++; if (timed_out) begin n_fail++; $display("FAIL rnd_timeout: iter %0d got no done expected done", it); end
         n_tests++; if (gnt_idx != exp_idx || done_seen !== onehot(exp_idx)) begin n_fail++; $display("FAIL rnd_owner: iter %0d got gnt %0d done %b expected %0d", it, gnt_idx, done_seen, exp_idx); end
         n_tests++; if (pops != exp_pops || short_seen !== exp_short) begin n_fail++; $display("FAIL rnd_pops: iter %0d got %0d short %b expected %0d short %b", it, pops, short_seen, exp_pops, exp_short); end
         if (exp_short) begin
            exp_done = (exp_pops > 0) ? last_pop_cyc + SM + 1 : first_gnt_cyc + SM;
            n_tests++; if (done_cyc != exp_done) begin n_fail++; $display("FAIL rnd_stall_cyc: iter %0d got %0d expected %0d", it, done_cyc, exp_done); end
         end
         drain(DL + 2);
         bad_owner = 0;
         foreach (beats_q[k]) if (beats_q[k] != exp_idx) bad_owner++;
         n_tests++; if (beats_q.size() != exp_pops || bad_owner != 0) begin n_fail++; $display("FAIL rnd_beats: iter %0d got %0d beats (%0d wrong owner) expected %0d owner %0d", it, beats_q.size(), bad_owner, exp_pops, exp_idx); end
         ptr_m = (exp_idx + 1) % NR;
      end
   endtask

   task automatic test_invariants();
      n_tests++; if (multi_gnt != 0)      begin n_fail++; $display("FAIL inv_onehot: got %0d cycles expected 0", multi_gnt); end
      n_tests++; if (en_while_empty != 0) begin n_fail++; $display("FAIL inv_en_empty: got %0d cycles expected 0", en_while_empty); end
      n_tests++; if (en_outside != 0)     begin n_fail++; $display("FAIL inv_en_outside: got %0d cycles expected 0", en_outside); end
      n_tests++; if (short_stray != 0)    begin n_fail++; $display("FAIL inv_short: got %0d cycles expected 0", short_stray); end
   endtask

   initial begin
      test_reset();
      test_round_robin();
      test_single();
      test_stall_gap();
      test_stall_timeout();
      test_clamp();
      test_reset_mid();
      test_random();
      test_invariants();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
